// File: rtl/illm_row_unpack.sv
// Serial-to-row deserializer: collects 8 coefficients and hands them to the
// 8-lane row stage as one lockstep transfer; end-of-stream fans out to all lanes.
//
//   state  | meaning
//   S_FILL | accepting serial tokens into slot[cnt]
//   S_FULL | complete row presented on all lanes, waiting for all-lane ready
//   S_EOS  | end-of-stream marker presented on all lanes
module illm_row_unpack #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] in_d,
  input  logic         in_v,
  input  logic         in_e,
  output logic         in_b,
  output logic [W-1:0] b0_d,
  output logic [W-1:0] b1_d,
  output logic [W-1:0] b2_d,
  output logic [W-1:0] b3_d,
  output logic [W-1:0] b4_d,
  output logic [W-1:0] b5_d,
  output logic [W-1:0] b6_d,
  output logic [W-1:0] b7_d,
  output logic         b0_v,
  output logic         b1_v,
  output logic         b2_v,
  output logic         b3_v,
  output logic         b4_v,
  output logic         b5_v,
  output logic         b6_v,
  output logic         b7_v,
  output logic         b0_e,
  output logic         b1_e,
  output logic         b2_e,
  output logic         b3_e,
  output logic         b4_e,
  output logic         b5_e,
  output logic         b6_e,
  output logic         b7_e,
  input  logic         b0_b,
  input  logic         b1_b,
  input  logic         b2_b,
  input  logic         b3_b,
  input  logic         b4_b,
  input  logic         b5_b,
  input  logic         b6_b,
  input  logic         b7_b,
  output logic         frag_err
);

  typedef enum logic [1:0] {S_FILL, S_FULL, S_EOS} state_t;

  state_t       state;
  logic [2:0]   cnt;
  logic [W-1:0] slot [8];
  logic         all_ready;
  logic         lane_v;
  logic         lane_e;
  logic [W-1:0] lane_d [8];

  // A row moves only when every lane is ready in the same cycle.
  assign all_ready = ~|{b7_b, b6_b, b5_b, b4_b, b3_b, b2_b, b1_b, b0_b};

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_FILL;
      cnt      <= 3'd0;
      frag_err <= 1'b0;
      for (int i = 0; i < 8; i++) slot[i] <= '0;
    end else begin
      case (state)
        S_FILL: begin
          if (in_v) begin
            if (!in_e) begin
              slot[cnt] <= in_d;
              cnt       <= cnt + 3'd1;
              if (cnt == 3'd7) state <= S_FULL;
            end else begin
              if (cnt != 3'd0) frag_err <= 1'b1;
              cnt   <= 3'd0;
              state <= S_EOS;
            end
          end
        end
        S_FULL, S_EOS: begin
          if (all_ready) state <= S_FILL;
        end
        default: state <= S_FILL;
      endcase
    end
  end

  // Reset masks the decodes so nothing looks valid or acceptable during reset.
  assign in_b   = reset || (state != S_FILL);
  assign lane_v = !reset && (state != S_FILL);
  assign lane_e = !reset && (state == S_EOS);

  always_comb begin
    for (int i = 0; i < 8; i++) lane_d[i] = (state == S_FULL) ? slot[i] : '0;
  end

  assign b0_d = lane_d[0];
  assign b1_d = lane_d[1];
  assign b2_d = lane_d[2];
  assign b3_d = lane_d[3];
  assign b4_d = lane_d[4];
  assign b5_d = lane_d[5];
  assign b6_d = lane_d[6];
  assign b7_d = lane_d[7];

  assign b0_v = lane_v;
  assign b1_v = lane_v;
  assign b2_v = lane_v;
  assign b3_v = lane_v;
  assign b4_v = lane_v;
  assign b5_v = lane_v;
  assign b6_v = lane_v;
  assign b7_v = lane_v;

  assign b0_e = lane_e;
  assign b1_e = lane_e;
  assign b2_e = lane_e;
  assign b3_e = lane_e;
  assign b4_e = lane_e;
  assign b5_e = lane_e;
  assign b6_e = lane_e;
  assign b7_e = lane_e;

endmodule

// File: tb/tb_illm_row_unpack.sv
// Directed bench for illm_row_unpack: inputs change and outputs are checked on
// the falling clock edge, expected values are hand-derived constants.
module tb_illm_row_unpack;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] in_d;
  logic        in_v;
  logic        in_e;
  logic        in_b;
  logic [15:0] bd [8];
  logic        bv [8];
  logic        be [8];
  logic        bb [8];
  logic        frag_err;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  illm_row_unpack #(.W(16)) dut (
    .clock(clk), .reset(reset),
    .in_d(in_d), .in_v(in_v), .in_e(in_e), .in_b(in_b),
    .b0_d(bd[0]), .b1_d(bd[1]), .b2_d(bd[2]), .b3_d(bd[3]),
    .b4_d(bd[4]), .b5_d(bd[5]), .b6_d(bd[6]), .b7_d(bd[7]),
    .b0_v(bv[0]), .b1_v(bv[1]), .b2_v(bv[2]), .b3_v(bv[3]),
    .b4_v(bv[4]), .b5_v(bv[5]), .b6_v(bv[6]), .b7_v(bv[7]),
    .b0_e(be[0]), .b1_e(be[1]), .b2_e(be[2]), .b3_e(be[3]),
    .b4_e(be[4]), .b5_e(be[5]), .b6_e(be[6]), .b7_e(be[7]),
    .b0_b(bb[0]), .b1_b(bb[1]), .b2_b(bb[2]), .b3_b(bb[3]),
    .b4_b(bb[4]), .b5_b(bb[5]), .b6_b(bb[6]), .b7_b(bb[7]),
    .frag_err(frag_err)
  );

  function automatic logic [7:0] v_pack();
    logic [7:0] r;
    for (int k = 0; k < 8; k++) r[k] = bv[k];
    return r;
  endfunction

  function automatic logic [7:0] e_pack();
    logic [7:0] r;
    for (int k = 0; k < 8; k++) r[k] = be[k];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic send(input logic [15:0] d, input logic e);
    in_v = 1'b1; in_d = d; in_e = e;
    @(negedge clk);
    in_v = 1'b0; in_e = 1'b0;
  endtask

  task automatic chk_row(input string tag, input logic [15:0] base);
    chk({tag, "_v"}, {24'd0, v_pack()}, 32'h0000_00ff);
    chk({tag, "_e"}, {24'd0, e_pack()}, 32'h0);
    chk({tag, "_inb"}, {31'd0, in_b}, 32'h1);
    for (int k = 0; k < 8; k++)
      chk($sformatf("%s_d%0d", tag, k), {16'd0, bd[k]}, {16'd0, base + 16'(k)});
  endtask

  task automatic chk_eos(input string tag);
    logic [15:0] any_d;
    any_d = '0;
    for (int k = 0; k < 8; k++) any_d = any_d | bd[k];
    chk({tag, "_v"}, {24'd0, v_pack()}, 32'h0000_00ff);
    chk({tag, "_e"}, {24'd0, e_pack()}, 32'h0000_00ff);
    chk({tag, "_d"}, {16'd0, any_d}, 32'h0);
    chk({tag, "_inb"}, {31'd0, in_b}, 32'h1);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_v"}, {24'd0, v_pack()}, 32'h0);
    chk({tag, "_e"}, {24'd0, e_pack()}, 32'h0);
    chk({tag, "_inb"}, {31'd0, in_b}, 32'h0);
  endtask

  initial begin
    reset = 1'b1; in_d = '0; in_v = 1'b0; in_e = 1'b0;
    for (int k = 0; k < 8; k++) bb[k] = 1'b0;

    // reset state
    tick();
    chk("rst_inb", {31'd0, in_b}, 32'h1);
    chk("rst_v", {24'd0, v_pack()}, 32'h0);
    chk("rst_e", {24'd0, e_pack()}, 32'h0);
    chk("rst_frag", {31'd0, frag_err}, 32'h0);
    reset = 1'b0;
    tick();
    chk_idle("idle0");

    // basic row 1..8
    for (int i = 0; i < 8; i++) begin
      if (i == 4) chk_idle("basic_mid");
      send(16'(i + 1), 1'b0);
    end
    chk_row("basic", 16'h0001);
    tick();
    chk_idle("basic_after");

    // lockstep stall on lane 5, with upstream pushing during the stall
    bb[5] = 1'b1;
    for (int i = 0; i < 8; i++) send(16'(16'h10 + i), 1'b0);
    in_v = 1'b1; in_d = 16'h00aa;
    for (int c = 0; c < 4; c++) begin
      chk_row($sformatf("stall%0d", c), 16'h0010);
      if (c < 3) tick();
    end
    bb[5] = 1'b0; in_v = 1'b0;
    tick();
    chk_idle("stall_fire");
    for (int i = 0; i < 8; i++) send(16'(16'h20 + i), 1'b0);
    chk_row("post_stall", 16'h0020);

    // lane 3 alone also blocks the row
    bb[3] = 1'b1;
    tick();
    chk_row("lane3_hold", 16'h0020);
    bb[3] = 1'b0;
    tick();
    chk_idle("lane3_fire");

    // clean end-of-stream
    for (int i = 0; i < 8; i++) send(16'(16'h30 + i), 1'b0);
    chk_row("clean_row", 16'h0030);
    tick();
    chk_idle("clean_gap");
    send(16'h0000, 1'b1);
    chk_eos("clean_eos");
    chk("clean_frag", {31'd0, frag_err}, 32'h0);
    tick();
    chk_idle("clean_after");

    // fragment: 3 tokens then eos
    for (int i = 0; i < 3; i++) send(16'(16'h40 + i), 1'b0);
    send(16'h0000, 1'b1);
    chk_eos("frag_eos");
    chk("frag_set", {31'd0, frag_err}, 32'h1);
    tick();
    chk_idle("frag_after");
    for (int i = 0; i < 8; i++) send(16'(16'h50 + i), 1'b0);
    chk_row("frag_row", 16'h0050);
    chk("frag_sticky", {31'd0, frag_err}, 32'h1);
    tick();

    // input gaps with in_e pulses while in_v=0
    for (int i = 0; i < 8; i++) begin
      send(16'(16'h60 + i), 1'b0);
      if (i < 7) begin
        in_v = 1'b0; in_e = 1'b1; in_d = 16'hdead;
        tick();
        in_e = 1'b0;
        if (i == 3) chk_idle("gap_mid");
      end
    end
    chk_row("gap_row", 16'h0060);
    tick();
    chk_idle("gap_after");

    // reset after 5 tokens
    for (int i = 0; i < 5; i++) send(16'(16'h70 + i), 1'b0);
    reset = 1'b1;
    #1;
    chk("rstmid_inb", {31'd0, in_b}, 32'h1);
    tick();
    reset = 1'b0;
    #1;
    chk_idle("rstmid_after");
    chk("rstmid_frag", {31'd0, frag_err}, 32'h0);

    // reset while FULL and stalled
    tick();
    bb[0] = 1'b1;
    for (int i = 0; i < 8; i++) send(16'(16'h80 + i), 1'b0);
    chk_row("rstfull_row", 16'h0080);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bb[0] = 1'b0;
    #1;
    chk_idle("rstfull_after");
    tick();
    chk_idle("rstfull_idle");
    for (int i = 0; i < 8; i++) send(16'(16'h90 + i), 1'b0);
    chk_row("rstfull_new", 16'h0090);
    tick();
    chk_idle("rstfull_once");
    chk("final_frag", {31'd0, frag_err}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
